// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared widths, opcodes and FSM state type for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;
    localparam int MDU_DW    = 32;
    localparam int MDU_CNT_W = 6;

    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative unsigned restoring divider, one quotient bit per step.
// quotient/remainder show the result of the step taken at the next edge, so the final values are valid while last is high.
module mdu_div_core
    import mdu_hilo_pkg::*;
#(
    parameter int DW    = MDU_DW,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          step,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          last
);
    logic [DW-1:0]    rem, quo, dvs;
    logic [CNT_W-1:0] cnt;
    logic [DW:0]      shifted, diff;
    logic             ge;

    always_comb begin
        shifted   = {rem, quo[DW-1]};
        diff      = shifted - {1'b0, dvs};
        ge        = !diff[DW];
        remainder = ge ? diff[DW-1:0] : shifted[DW-1:0];
        quotient  = {quo[DW-2:0], ge};
        last      = step && cnt == CNT_W'(DW - 1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= '0;
        end else if (step) begin
            rem <= remainder;
            quo <= quotient;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU take one extra edge, DIV/DIVU take 32 divider steps; divide-by-zero completes immediately.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int DW    = MDU_DW,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    output logic          busy,
    output logic          done,
    output logic          div_zero,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);
    state_t          state, state_nx;
    logic            accept, is_mul, is_div, signed_op, load, dz, step, mul_fire, div_fin, last;
    logic            mul_sgn, neg_q, neg_r;
    logic [DW-1:0]   a_r, b_r, div_a, div_b, quo, rem;
    logic [2*DW-1:0] ma, mb, prod;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (accept && is_mul) ? MUL : load ? DIV : IDLE;
            MUL:     state_nx = IDLE;
            DIV:     state_nx = last ? IDLE : DIV;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        is_mul    = op == MDU_MULT || op == MDU_MULTU;
        is_div    = op == MDU_DIV || op == MDU_DIVU;
        signed_op = op == MDU_MULT || op == MDU_DIV;
        busy      = state != IDLE;
        accept    = start && state == IDLE;
        load      = accept && is_div && src_b != '0;
        dz        = accept && is_div && src_b == '0;
        step      = state == DIV;
        mul_fire  = state == MUL;
        div_fin   = step && last;
    end

    // The divider works on magnitudes; signs are reapplied when the result is committed.
    always_comb begin
        div_a = (signed_op && src_a[DW-1]) ? -src_a : src_a;
        div_b = (signed_op && src_b[DW-1]) ? -src_b : src_b;
        ma    = {{DW{mul_sgn & a_r[DW-1]}}, a_r};
        mb    = {{DW{mul_sgn & b_r[DW-1]}}, b_r};
        prod  = ma * mb;
    end

    mdu_div_core #(.DW(DW), .CNT_W(CNT_W)) u_div (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .dividend  (div_a),
        .divisor   (div_b),
        .step      (step),
        .quotient  (quo),
        .remainder (rem),
        .last      (last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            mul_sgn  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done     <= mul_fire || div_fin || dz;
            div_zero <= dz;
            if (accept) begin
                a_r     <= src_a;
                b_r     <= src_b;
                mul_sgn <= signed_op;
                neg_q   <= signed_op && (src_a[DW-1] ^ src_b[DW-1]);
                neg_r   <= signed_op && src_a[DW-1];
            end
            if (mul_fire) begin
                {hi, lo} <= prod;
            end else if (div_fin) begin
                lo <= neg_q ? -quo : quo;
                hi <= neg_r ? -rem : rem;
            end else if (accept && op == MDU_MTHI) begin
                hi <= src_a;
            end else if (accept && op == MDU_MTLO) begin
                lo <= src_a;
            end
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vectors with a scoreboard; a negedge monitor pops and checks every done pulse.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    exp_t        sb[$];
    exp_t        e;
    int          tests = 0, fails = 0, cyc = 0;

    mdu_hilo dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
                check("sb_div_zero", 32'(div_zero), 32'(e.dz));
                check("sb_latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int lat);
        exp_t x;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; op = 3'd0; src_a = $urandom; src_b = $urandom;
        if (push) begin
            x.hi = eh; x.lo = el; x.dz = ed; x.lat = lat; x.t0 = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1);
        check("mult_busy", 32'(busy), 32'd1);
        wait_done(); @(negedge clock);
        issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1);
        wait_done(); @(negedge clock);
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32);
        wait_done(); @(negedge clock);
        issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 32);
        wait_done(); @(negedge clock);
        issue(MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD, 1'b0, 32);
        wait_done(); @(negedge clock);
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0, 32);
        wait_done(); @(negedge clock);

        issue(MDU_MTHI, 32'h11, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        check("preset_hi", hi, 32'h11);
        issue(MDU_MTLO, 32'h22, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        check("preset_lo", lo, 32'h22);
        issue(MDU_DIV, 32'd5, 32'd0, 1'b1, 32'h11, 32'h22, 1'b1, 0);
        check("dz_busy", 32'(busy), 32'd0);
        check("dz_done", 32'(done), 32'd1);
        @(negedge clock); @(negedge clock);
        check("dz_pulse", 32'(done), 32'd0);

        issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 32);
        repeat (5) @(negedge clock);
        issue(MDU_MULT, 32'd3, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        check("ignored_busy", 32'(busy), 32'd1);
        wait_done();
        issue(MDU_MULT, 32'd5, 32'd6, 1'b1, 32'h0, 32'd30, 1'b0, 1);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(); @(negedge clock);

        issue(MDU_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(MDU_MTLO, 32'h12345678, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        check("mtlo_lo", lo, 32'h12345678);
        check("mtlo_hi", hi, 32'hDEADBEEF);
        @(negedge clock);
        check("mtx_done", 32'(done), 32'd0);

        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_busy_after", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
